// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 divider, radix-2 restoring, RNE rounding.
// Define FP_DIV_SUBNORM_EN for subnormal support; default flushes to zero.
module fp_div_seq #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   strt,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   z,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int Q  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(Q + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND} st_t;

  st_t st;
  logic [W-1:0] ra, rb, sres;
  logic [3:0] sflg;
  logic sgn, spec, stk;
  logic signed [EW-1:0] e;
  logic [MAN_W:0] mb;
  logic [MAN_W+1:0] rem;
  logic [Q-1:0] q;
  logic [CW-1:0] cnt;

  logic [EXP_W-1:0] xa, xb;
  logic [MAN_W-1:0] fa, fb;
  assign {xa, fa} = ra[W-2:0];
  assign {xb, fb} = rb[W-2:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic nan_r, nv, is_spec, s_n;
  logic [MAN_W:0] ma, mbn;
  logic signed [EW-1:0] va, vb, eu;
  logic [W-1:0] sres_n;

`ifdef FP_DIV_SUBNORM_EN
  localparam int LW = $clog2(MAN_W + 1);
  logic [LW-1:0] la, lb;

  function automatic logic [LW-1:0] lzc(input logic [MAN_W-1:0] f);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < MAN_W; i++)
      if (f[i]) n = LW'(MAN_W - 1 - i);
    return n;
  endfunction
`endif

  always_comb begin
    a_nan = (&xa) & (|fa);
    b_nan = (&xb) & (|fb);
    a_inf = (&xa) & ~(|fa);
    b_inf = (&xb) & ~(|fb);
    ma  = {1'b1, fa};
    mbn = {1'b1, fb};
    va  = EW'(xa);
    vb  = EW'(xb);
`ifdef FP_DIV_SUBNORM_EN
    a_zero = ~(|xa) & ~(|fa);
    b_zero = ~(|xb) & ~(|fb);
    la = lzc(fa);
    lb = lzc(fb);
    // subnormal 0.f * 2^(1-bias) becomes 1.f' * 2^(-lz-bias)
    if (~(|xa)) begin
      ma = {1'b1, fa << (la + LW'(1))};
      va = EW'(0) - EW'(la);
    end
    if (~(|xb)) begin
      mbn = {1'b1, fb << (lb + LW'(1))};
      vb  = EW'(0) - EW'(lb);
    end
`else
    a_zero = ~(|xa);
    b_zero = ~(|xb);
`endif
    eu = va - vb + BIAS;
    s_n = ra[W-1] ^ rb[W-1];
    nan_r = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    nv = (a_zero & b_zero) | (a_inf & b_inf) |
         (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]);
    is_spec = nan_r | a_inf | b_inf | a_zero | b_zero;
    if (nan_r)
      sres_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (b_zero | a_inf)
      sres_n = {s_n, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      sres_n = {s_n, {(W-1){1'b0}}};
  end

  logic ge;
  logic [MAN_W:0] diff;
  assign ge   = rem >= {1'b0, mb};
  assign diff = ge ? (MAN_W+1)'(rem - {1'b0, mb}) : rem[MAN_W:0];

  logic tiny, sx, up;
  logic [Q-1:0] m;
  logic [MAN_W+1:0] rnd;
  logic signed [EW-1:0] ef;
  logic [W-1:0] zr;
  logic [3:0] fr;
`ifdef FP_DIV_SUBNORM_EN
  logic [EW-1:0] sh, shc;
  logic [2*Q+1:0] ext;
`endif

  always_comb begin
    tiny = e[EW-1] | (e == '0);
    m  = q;
    sx = stk;
`ifdef FP_DIV_SUBNORM_EN
    sh  = EW'(1) - e;
    shc = (sh > EW'(Q + 1)) ? EW'(Q + 1) : sh;
    ext = {q, {(Q + 2){1'b0}}} >> shc;
    if (tiny) begin
      m  = ext[2*Q+1:Q+2];
      sx = stk | (|ext[Q+1:0]);
    end
`endif
    up  = m[1] & (m[0] | sx | m[2]);
    rnd = {1'b0, m[Q-1:2]} + (MAN_W+2)'(up);
    // top two bits of rnd carry hidden bit and carry-out
    ef  = (tiny ? EW'(1) : e) - EW'(1) + EW'(rnd[MAN_W+1:MAN_W]);
    zr  = {sgn, ef[EXP_W-1:0], rnd[MAN_W-1:0]};
    fr  = 4'b0000;
    if (ef >= EMAX) begin
      zr = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fr = 4'b0010;
    end
`ifdef FP_DIV_SUBNORM_EN
    if (tiny) fr = {3'b000, m[1] | m[0] | sx};
`else
    if (tiny) begin
      zr = {sgn, {(W-1){1'b0}}};
      fr = 4'b0001;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      ra <= '0;
      rb <= '0;
      sres <= '0;
      sflg <= '0;
      sgn <= 1'b0;
      spec <= 1'b0;
      stk <= 1'b0;
      e <= '0;
      mb <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      z <= '0;
      flags <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: if (strt) begin
          ra <= a;
          rb <= b;
          busy <= 1'b1;
          st <= UNPACK;
        end
        UNPACK: begin
          sgn <= s_n;
          spec <= is_spec;
          sres <= sres_n;
          sflg <= {nv, b_zero & ~a_inf & ~nan_r, 2'b00};
          e <= eu;
          mb <= mbn;
          rem <= {1'b0, ma};
          q <= '0;
          cnt <= '0;
          st <= is_spec ? ROUND : DIVIDE;
        end
        DIVIDE: begin
          q <= {q[Q-2:0], ge};
          rem <= {diff, 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(Q - 1)) st <= NORM;
        end
        NORM: begin
          if (!q[Q-1]) begin
            q <= {q[Q-2:0], 1'b0};
            e <= e - EW'(1);
          end
          stk <= |rem;
          st <= ROUND;
        end
        ROUND: begin
          z <= spec ? sres : zr;
          flags <= spec ? sflg : fr;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed and random checks of fp_div_seq
// against a real-arithmetic reference model.
module tb_fp_div_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ds, ss;
  logic [63:0] da, db, dz;
  logic [31:0] sa, sb, sz;
  logic dbusy, ddone, sbusy, sdone;
  logic [3:0] dfl, sfl;

  fp_div_seq #(.EXP_W(11), .MAN_W(52)) u_d (
    .clk(clk), .reset(rst_n), .strt(ds), .a(da), .b(db),
    .z(dz), .busy(dbusy), .done(ddone), .flags(dfl)
  );

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) u_s (
    .clk(clk), .reset(rst_n), .strt(ss), .a(sa), .b(sb),
    .z(sz), .busy(sbusy), .done(sdone), .flags(sfl)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: IEEE rules on classes, host double division otherwise
  task automatic ref_d(input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] z, output logic [3:0] fl,
                       output bit sp);
    logic [10:0] xa, xb;
    logic [51:0] fa, fb;
    bit an, bn, ai, bi, az, bz, s, nv;
    real r;
    logic [63:0] rb;
    {xa, fa} = a[62:0];
    {xb, fb} = b[62:0];
    s  = a[63] ^ b[63];
    an = (xa == 11'h7FF) && (fa != 0);
    bn = (xb == 11'h7FF) && (fb != 0);
    ai = (xa == 11'h7FF) && (fa == 0);
    bi = (xb == 11'h7FF) && (fb == 0);
`ifdef FP_DIV_SUBNORM_EN
    az = (a[62:0] == 0);
    bz = (b[62:0] == 0);
`else
    az = (xa == 0);
    bz = (xb == 0);
`endif
    fl = 4'b0000;
    sp = 1'b1;
    if (an || bn || (az && bz) || (ai && bi)) begin
      z  = 64'h7FF8000000000000;
      nv = (az && bz) || (ai && bi) || (an && !fa[51]) || (bn && !fb[51]);
      fl = {nv, 3'b000};
    end else if (bz) begin
      z  = {s, 11'h7FF, 52'h0};
      fl = {1'b0, !ai, 2'b00};
    end else if (ai) begin
      z = {s, 11'h7FF, 52'h0};
    end else if (bi || az) begin
      z = {s, 63'h0};
    end else begin
      sp = 1'b0;
      r  = $bitstoreal(a) / $bitstoreal(b);
      rb = $realtobits(r);
      z  = rb;
      if (rb[62:52] == 11'h7FF) fl = 4'b0010;
      else if (rb[62:52] == 0) begin
`ifdef FP_DIV_SUBNORM_EN
        fl[0] = ($bitstoreal(rb) * $bitstoreal(b) != $bitstoreal(a));
`else
        z = {s, 63'h0};
        fl[0] = 1'b1;
`endif
      end
    end
  endtask

  task automatic op_d(input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] z, output logic [3:0] fl,
                      output int lat, output bit bok);
    @(negedge clk);
    da = a;
    db = b;
    ds = 1'b1;
    @(posedge clk);
    #1;
    ds = 1'b0;
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    bok = dbusy && !ddone;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ddone) begin
        bok = bok && !dbusy;
        break;
      end
      bok = bok && dbusy;
    end
    z = dz;
    fl = dfl;
  endtask

  task automatic op_s(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] z, output logic [3:0] fl,
                      output int lat);
    @(negedge clk);
    sa = a;
    sb = b;
    ss = 1'b1;
    @(posedge clk);
    #1;
    ss = 1'b0;
    sa = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (sdone) break;
    end
    z = sz;
    fl = sfl;
  endtask

  function automatic logic [51:0] rf();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[51:0];
  endfunction

  function automatic logic [63:0] mk(input int ex, input logic [51:0] f);
    logic s;
    s = 1'($urandom_range(0, 1));
    return {s, 11'(ex), f};
  endfunction

  function automatic logic [63:0] rspec();
    logic [51:0] f;
    f = rf();
    case ($urandom_range(0, 4))
      0: return mk(0, 52'h0);
      1: return mk(2047, 52'h0);
      2: return mk(2047, {1'b1, f[50:0]});
      3: return mk(2047, {1'b0, f[50:0] | 51'd1});
      default: return mk($urandom_range(900, 1100), f);
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] z, ea, eb, ez, zc;
    logic [31:0] z32;
    logic [3:0] fl, efl;
    int lat, cnt;
    bit bok, sp;

    rst_n = 1'b0;
    ds = 1'b0;
    ss = 1'b0;
    da = '0;
    db = '0;
    sa = '0;
    sb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset z", dz, 64'h0);
    chk("reset flags", 64'(dfl), 64'h0);
    chk("reset busy/done", {62'h0, dbusy, ddone}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    op_d(64'h4018000000000000, 64'h4008000000000000, z, fl, lat, bok);
    chk("6/3 z", z, 64'h4000000000000000);
    chk("6/3 flags", 64'(fl), 64'h0);
    chk("6/3 latency", 64'(lat), 64'd58);
    chk("6/3 busy", 64'(bok), 64'd1);
    @(posedge clk);
    #1;
    chk("done pulse", 64'(ddone), 64'd0);

    op_d(64'h3FF0000000000000, 64'h4008000000000000, z, fl, lat, bok);
    chk("1/3 dp z", z, 64'h3FD5555555555555);

    op_s(32'h3F800000, 32'h40400000, z32, fl, lat);
    chk("1/3 sp z", 64'(z32), 64'h3EAAAAAB);
    chk("1/3 sp latency", 64'(lat), 64'd29);
    op_s(32'h3F800000, 32'h00000000, z32, fl, lat);
    chk("sp 1/0 z", 64'(z32), 64'h7F800000);
    chk("sp 1/0 flags", 64'(fl), 64'h4);

    op_d(64'h3FF0000000000000, 64'h0, z, fl, lat, bok);
    chk("1/0 z", z, 64'h7FF0000000000000);
    chk("1/0 flags", 64'(fl), 64'h4);
    chk("1/0 latency", 64'(lat), 64'd2);
    chk("1/0 busy", 64'(bok), 64'd1);
    op_d(64'h0, 64'h0, z, fl, lat, bok);
    chk("0/0 z", z, 64'h7FF8000000000000);
    chk("0/0 flags", 64'(fl), 64'h8);
    chk("0/0 latency", 64'(lat), 64'd2);

    op_d(64'h0010000000000001, 64'h4000000000000000, z, fl, lat, bok);
`ifdef FP_DIV_SUBNORM_EN
    chk("tiny z", z, 64'h0008000000000000);
`else
    chk("tiny z", z, 64'h0);
`endif
    chk("tiny flags", 64'(fl), 64'h1);
    chk("tiny latency", 64'(lat), 64'd58);

    op_d(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, z, fl, lat, bok);
    chk("ovf z", z, 64'h7FF0000000000000);
    chk("ovf flags", 64'(fl), 64'h2);

    @(negedge clk);
    da = 64'h4018000000000000;
    db = 64'h4008000000000000;
    ds = 1'b1;
    @(posedge clk);
    #1 ds = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset z", dz, 64'h0);
    chk("mid reset flags", 64'(dfl), 64'h0);
    chk("mid reset busy/done", {62'h0, dbusy, ddone}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (ddone) cnt++;
    end
    chk("mid reset no done", 64'(cnt), 64'd0);

    @(negedge clk);
    da = 64'h4018000000000000;
    db = 64'h4008000000000000;
    ds = 1'b1;
    @(posedge clk);
    #1 ds = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    da = 64'h3FF0000000000000;
    ds = 1'b1;
    @(negedge clk) ds = 1'b0;
    cnt = 0;
    zc = '0;
    repeat (130) begin
      @(posedge clk);
      #1;
      if (ddone) begin
        cnt++;
        zc = dz;
      end
    end
    chk("busy strt done count", 64'(cnt), 64'd1);
    chk("busy strt z", zc, 64'h4000000000000000);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        5: begin
          ea = mk($urandom_range(1900, 2046), rf());
          eb = mk($urandom_range(1, 100), rf());
        end
        6: begin
          ea = mk($urandom_range(1, 100), rf());
          eb = mk($urandom_range(1900, 2046), rf());
        end
        7: begin
          ea = mk(0, rf());
          eb = mk($urandom_range(1, 40), rf());
        end
        8: begin
          ea = mk($urandom_range(1900, 2046), rf());
          eb = mk(0, rf());
        end
        9: begin
          ea = rspec();
          eb = rspec();
        end
        default: begin
          ea = mk($urandom_range(623, 1423), rf());
          eb = mk($urandom_range(623, 1423), rf());
        end
      endcase
      ref_d(ea, eb, ez, efl, sp);
      op_d(ea, eb, z, fl, lat, bok);
      chk($sformatf("rand%0d z %h/%h", i, ea, eb), z, ez);
      chk($sformatf("rand%0d flags", i), 64'(fl), 64'(efl));
      chk($sformatf("rand%0d latency", i), 64'(lat), sp ? 64'd2 : 64'd58);
      chk($sformatf("rand%0d busy", i), 64'(bok), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised sequential IEEE-754 divider, successor to the fixed double-precision `div_dp`. Computes `z = a / b` for any binary interchange format selected by exponent/mantissa width parameters using a radix-2 restoring mantissa divider. Adds a busy/done handshake, special-value handling, round-to-nearest-even and exception flags. Sits in the `div` datapath alongside the existing divider and is driven by the same `strt`-pulse controllers.

## Interface

- `EXP_W`, 11, exponent field width (8 = single, 11 = double)
- `MAN_W`, 52, stored fraction width (23 = single, 52 = double); `W = 1+EXP_W+MAN_W`
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `strt`  in  1  start request, sampled only in IDLE
- `a`  in  W  dividend
- `b`  in  W  divisor
- `z`  out  W  quotient, held until next completion
- `busy`  out  1  high from the cycle after accepted `strt` until `done`
- `done`  out  1  one-cycle pulse, `z`/`flags` valid from that cycle
- `flags`  out  4  {nv, dz, of, uf}, held with `z`

## Operation

- States: IDLE, UNPACK, DIVIDE, NORM, ROUND.
- IDLE: `strt`=1 at a rising edge captures `a`, `b` into registers; → UNPACK. Operands may change afterwards.
- UNPACK: sign = sa^sb; classify. Special results go straight to output (done, → IDLE):
  - either NaN, 0/0, inf/inf → canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0); nv=1 for 0/0, inf/inf, or any signalling NaN (fraction MSB 0).
  - finite nonzero / 0 → signed inf, dz=1. inf / finite → signed inf. finite / inf, 0 / nonzero → signed 0. No flags.
  - otherwise: biased exponent e = ea − eb + BIAS (BIAS = 2^(EXP_W−1)−1), held in EXP_W+2 signed bits; → DIVIDE.
- DIVIDE: Q = MAN_W+3 iterations, one quotient bit per cycle, of (1.fa)/(1.fb); quotient in (0.5, 2). Sticky = remainder ≠ 0 at end.
- NORM: if leading quotient bit 0, shift left 1, e −= 1. Tiny when e ≤ 0.
- ROUND: round-to-nearest-even on guard/round/sticky; mantissa carry-out increments e. e ≥ 2^EXP_W−1 → signed inf, of=1. Register `z`, `flags`, pulse `done`; → IDLE.
- `strt` while busy is ignored; no queueing.
- Reset (async, any state): state IDLE, `z`=0, `flags`=0, `busy`=0, `done`=0; an in-flight operation is discarded with no `done`.

## Timing

- `strt` accepted at edge k. Normal path: `done`=1 in the cycle following edge k+MAN_W+6 (58 cycles double, 29 single). Special path: `done` after edge k+2.
- Latency is independent of operand values within each path and of `SUBNORM_EN`.
- `busy` rises after edge k, falls in the same edge that raises `done`. Next `strt` accepted at the edge ending the `done` cycle at earliest.

## Configuration

- `FP_DIV_SUBNORM_EN` defined: subnormal operands normalised in UNPACK by combinational leading-zero count (exponent adjusted); tiny results are denormalised by right shift before rounding, sticky accumulated; uf=1 when tiny and inexact.
- Undefined: subnormal operands treated as signed zero; tiny results flushed to signed zero with uf=1.

## Test plan

- Double: a=0x4018000000000000 (6.0), b=0x4008000000000000 (3.0) → z=0x4000000000000000, flags=0, `done` exactly 58 cycles after `strt`.
- Double 1/3: a=0x3FF0000000000000, b=0x4008000000000000 → z=0x3FD5555555555555; single (EXP_W=8, MAN_W=23) 0x3F800000/0x40400000 → z=0x3EAAAAAB.
- Specials: 1.0/+0 → 0x7FF0000000000000, dz=1; 0/0 → 0x7FF8000000000000, nv=1; both `done` after 2 cycles.
- Overflow: 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 → 0x7FF0000000000000, of=1.
- Tiny: 0x0010000000000001 / 0x4000000000000000 → with `FP_DIV_SUBNORM_EN` z=0x0008000000000000 (RNE tie to even), uf=1; without → z=0, uf=1.
- `reset` low mid-DIVIDE → outputs 0, no `done`; `strt` pulsed while busy → ignored, single `done`.
